list_sink_collector: RTL and testbench
======================================

// Module: list_sink_collector
// PURPOSE
//  Downstream consumer for a dfd list output port (req/ack/value/value_valid).
//  Pulls elements one at a time, accumulates count, sum and maximum, and
//  signals done at end-of-list. Sits between a generated dfd_* list producer
//  and board-level display/check logic.
// PARAMETERS
//  DATA_W    8     width of list_value and max_value
//  CNT_W     8     width of the element counter
//  SUM_W     16    width of the running sum
//  TIMEOUT   1024  cycles allowed in REQ with no ack before the error flag
// PORTS
//  clock        in   1       system clock; all logic on posedge
//  reset_n      in   1       synchronous, active-low reset
//  start        in   1       level; rising edge (0->1, seen while IDLE) begins a collection
//  done         out  1       high from end-of-list until the next start rising edge
//  list_req     out  1       element request to the producer
//  list_ack     in   1       producer: request serviced
//  list_value   in   DATA_W  element; sampled only when list_ack=1
//  list_valid   in   1       with list_ack: 1 = element, 0 = end of list
//  count        out  CNT_W   number of elements received
//  sum          out  SUM_W   sum of elements, zero-extended, saturating
//  max_value    out  DATA_W  largest element received; 0 if list empty
//  overflow     out  1       sticky: count wrapped or sum saturated
//  timeout      out  1       sticky: TIMEOUT expired in REQ
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): state IDLE; all outputs 0; start-edge
//   register cleared. Reset overrides everything, including mid-handshake.
//  States: IDLE, REQ, RELEASE, DONE, ERR.
//  IDLE: list_req=0. On a start rising edge: clear count/sum/max/overflow/
//   timeout/done and the timeout counter, then go to REQ.
//  REQ: list_req=1. Timeout counter increments each cycle.
//   - list_ack=1 & list_valid=1: latch element; count+1; sum+=value;
//     max=max(max,value); go to RELEASE.
//   - list_ack=1 & list_valid=0: end of list; done=1 next cycle; go to DONE.
//   - list_ack=0 & counter reaches TIMEOUT-1: timeout=1; go to ERR.
//  RELEASE: list_req=0. Stay until list_ack is sampled 0, then go to REQ and
//   clear the timeout counter. Four-phase handshake: list_req never
//   re-asserts while list_ack is still high.
//  DONE: list_req=0; outputs hold. Leave only on a new start rising edge
//   (acts as in IDLE). A start held high does not retrigger.
//  ERR: list_req=0; count/sum/max hold; done=1 with timeout=1. Leave only
//   on a start rising edge (acts as in IDLE).
//  Latency: list_req rises 1 cycle after the start edge is sampled. Results
//   update the cycle after the ack edge. done rises 1 cycle after the
//   end-of-list ack.
//  Arithmetic: sum saturates at 2^SUM_W-1 and sets overflow. count wraps
//   from 2^CNT_W-1 to 0 and sets overflow. max uses an unsigned compare.
//  Inputs outside REQ are ignored: list_ack in IDLE/DONE/ERR has no effect.
//   list_value is not sampled in RELEASE.
//  start falling or toggling mid-collection is ignored. Abort requires reset.
// TESTING
//  1 list {3,7,2}, ack 2 cycles after each req -> count=3, sum=12,
//    max=7, done=1, overflow=0; list_req low between every element.
//  2 empty list (first ack has valid=0) -> count=0, sum=0, max=0, done=1
//    one cycle after ack.
//  3 300 elements of 255, SUM_W=16, CNT_W=8 -> count=44, sum=65535 (saturated),
//    overflow=1, max=255.
//  4 producer holds ack high 5 cycles -> list_req stays 0 through RELEASE;
//    no double-count; count increments by exactly 1.
//  5 no ack, TIMEOUT=16 -> timeout=1 and done=1 after 16 req cycles,
//    list_req=0; next start edge clears both and restarts.
//  6 reset_n=0 in RELEASE after 2 elements -> next cycle all outputs 0,
//    IDLE; start edge runs a fresh collection from count=0.

Source files
------------

// File: rtl/list_sink_collector.sv
// Consumer for a four-phase req/ack list port: pulls elements one at a time and
// accumulates count, saturating sum and maximum, flagging end-of-list or a stalled producer.
module list_sink_collector #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned SUM_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              start_i,
    output logic              done_o,
    output logic              list_req_o,
    input  logic              list_ack_i,
    input  logic [DATA_W-1:0] list_value_i,
    input  logic              list_valid_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic [DATA_W-1:0] max_value_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRelease,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;

    logic              start_rise;
    logic [SUM_W:0]    sum_ext;

    assign start_rise = start_i & ~start_q;
    // One extra bit catches the carry that drives saturation.
    assign sum_ext    = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, list_value_i};

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        count_d    = count_q;
        sum_d      = sum_q;
        max_d      = max_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        done_d     = done_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_rise) begin
                    count_d    = '0;
                    sum_d      = '0;
                    max_d      = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    done_d     = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (list_ack_i) begin
                    if (list_valid_i) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == {CNT_W{1'b1}}) begin
                            overflow_d = 1'b1;
                        end
                        if (sum_ext[SUM_W]) begin
                            sum_d      = {SUM_W{1'b1}};
                            overflow_d = 1'b1;
                        end else begin
                            sum_d = sum_ext[SUM_W-1:0];
                        end
                        if (list_value_i > max_q) begin
                            max_d = list_value_i;
                        end
                        state_d = StRelease;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StErr;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StRelease: begin
                // Wait for the producer to drop ack before asking again.
                if (!list_ack_i) begin
                    tmo_cnt_d = '0;
                    state_d   = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            tmo_cnt_q  <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            tmo_cnt_q  <= tmo_cnt_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign list_req_o  = (state_q == StReq);
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign sum_o       = sum_q;
    assign max_value_o = max_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

    a_timeout_implies_done : assert property (
        @(posedge clock_i) disable iff (!reset_ni) timeout_o |-> done_o
    );

    a_no_req_while_ack_held : assert property (
        @(posedge clock_i) disable iff (!reset_ni)
        (state_q == StRelease && list_ack_i) |=> !list_req_o
    );

endmodule

// File: tb/tb_list_sink_collector.sv
// Self-checking bench for list_sink_collector: table of lists plus hand sequences for
// saturation, held ack, timeout, start-held and reset-in-RELEASE; per-element scoreboard.
module tb_list_sink_collector;

    localparam int unsigned DataW = 8;
    localparam int unsigned CntW  = 8;
    localparam int unsigned SumW  = 16;
    localparam int unsigned Tmo   = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic             done;
    logic             list_req;
    logic             list_ack;
    logic [DataW-1:0] list_value;
    logic             list_valid;
    logic [CntW-1:0]  count;
    logic [SumW-1:0]  sum;
    logic [DataW-1:0] max_value;
    logic             overflow;
    logic             timeout;

    always #5 clock = ~clock;

    list_sink_collector #(
        .DATA_W (DataW),
        .CNT_W  (CntW),
        .SUM_W  (SumW),
        .TIMEOUT(Tmo)
    ) dut (
        .clock_i     (clock),
        .reset_ni    (reset_n),
        .start_i     (start),
        .done_o      (done),
        .list_req_o  (list_req),
        .list_ack_i  (list_ack),
        .list_value_i(list_value),
        .list_valid_i(list_valid),
        .count_o     (count),
        .sum_o       (sum),
        .max_value_o (max_value),
        .overflow_o  (overflow),
        .timeout_o   (timeout)
    );

    typedef struct {
        logic [7:0]  cnt;
        logic [15:0] sum;
        logic [7:0]  max;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          len;
        logic [7:0]  vals [4];
        int          delay;
        int          hold;
        logic [7:0]  exp_cnt;
        logic [15:0] exp_sum;
        logic [7:0]  exp_max;
        logic        exp_ovf;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    int   sb_cnt;
    int   sb_sum;
    int   sb_max;
    logic sb_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic model_clear();
        sb_cnt = 0;
        sb_sum = 0;
        sb_max = 0;
        sb_ovf = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 64 && list_req !== 1'b1; i++) tick();
        check("req_wait", list_req, 1);
    endtask

    task automatic start_collection(input bit keep_high);
        start = 1'b0;
        tick();
        start = 1'b1;
        check("req_before_start", list_req, 0);
        tick();
        check("req_latency", list_req, 1);
        check("start_clr_count", count, 0);
        check("start_clr_done", done, 0);
        check("start_clr_timeout", timeout, 0);
        check("start_clr_ovf", overflow, 0);
        if (!keep_high) start = 1'b0;
        model_clear();
    endtask

    task automatic ack_element(input logic [7:0] v, input logic valid, input int delay);
        exp_t e;
        wait_req();
        for (int i = 0; i < delay; i++) begin
            check("req_held", list_req, 1);
            tick();
        end
        list_ack   = 1'b1;
        list_valid = valid;
        list_value = v;
        if (valid) begin
            if (sb_cnt == 255) sb_ovf = 1'b1;
            sb_cnt = (sb_cnt + 1) % 256;
            if (sb_sum + int'(v) > 65535) begin
                sb_sum = 65535;
                sb_ovf = 1'b1;
            end else begin
                sb_sum = sb_sum + int'(v);
            end
            if (int'(v) > sb_max) sb_max = int'(v);
            e.cnt = 8'(sb_cnt);
            e.sum = 16'(sb_sum);
            e.max = 8'(sb_max);
            e.ovf = sb_ovf;
            sb_q.push_back(e);
        end else begin
            check("done_before_eol", done, 0);
        end
        tick();
        check("req_low_after_ack", list_req, 0);
        if (valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_count", count, e.cnt);
            check("sb_sum", sum, e.sum);
            check("sb_max", max_value, e.max);
            check("sb_ovf", overflow, e.ovf);
        end else if (!valid) begin
            check("done_after_eol", done, 1);
        end
    endtask

    task automatic release_ack(input int hold);
        for (int h = 0; h < hold; h++) begin
            list_value = 8'($urandom);
            check("req_low_hold", list_req, 0);
            check("no_double_count", count, 8'(sb_cnt));
            tick();
        end
        list_ack   = 1'b0;
        list_valid = 1'b0;
        list_value = 8'hAA;
        tick();
    endtask

    vec_t tbl [5];
    int   n_req;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{len: 3, vals: '{8'd3, 8'd7, 8'd2, 8'd0}, delay: 2, hold: 0,
                   exp_cnt: 8'd3, exp_sum: 16'd12, exp_max: 8'd7, exp_ovf: 1'b0};
        tbl[1] = '{len: 0, vals: '{8'd0, 8'd0, 8'd0, 8'd0}, delay: 0, hold: 0,
                   exp_cnt: 8'd0, exp_sum: 16'd0, exp_max: 8'd0, exp_ovf: 1'b0};
        tbl[2] = '{len: 2, vals: '{8'd255, 8'd1, 8'd0, 8'd0}, delay: 0, hold: 0,
                   exp_cnt: 8'd2, exp_sum: 16'd256, exp_max: 8'd255, exp_ovf: 1'b0};
        tbl[3] = '{len: 4, vals: '{8'd5, 8'd200, 8'd9, 8'd200}, delay: 1, hold: 4,
                   exp_cnt: 8'd4, exp_sum: 16'd414, exp_max: 8'd200, exp_ovf: 1'b0};
        tbl[4] = '{len: 1, vals: '{8'd0, 8'd0, 8'd0, 8'd0}, delay: 3, hold: 1,
                   exp_cnt: 8'd1, exp_sum: 16'd0, exp_max: 8'd0, exp_ovf: 1'b0};

        reset_n    = 1'b0;
        start      = 1'b0;
        list_ack   = 1'b0;
        list_valid = 1'b0;
        list_value = 8'd0;
        model_clear();
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_sum", sum, 0);
        check("rst_max", max_value, 0);
        check("rst_done", done, 0);
        check("rst_req", list_req, 0);
        check("rst_ovf", overflow, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;

        // Ack while idle must be ignored.
        list_ack   = 1'b1;
        list_valid = 1'b1;
        list_value = 8'd99;
        tick();
        tick();
        check("idle_ack_count", count, 0);
        check("idle_ack_req", list_req, 0);
        check("idle_ack_done", done, 0);
        list_ack   = 1'b0;
        list_valid = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) begin
            start_collection(1'b0);
            for (int i = 0; i < tbl[t].len; i++) begin
                ack_element(tbl[t].vals[i], 1'b1, tbl[t].delay);
                release_ack(tbl[t].hold);
            end
            ack_element(8'h5A, 1'b0, tbl[t].delay);
            release_ack(0);
            check($sformatf("v%0d_count", t), count, tbl[t].exp_cnt);
            check($sformatf("v%0d_sum", t), sum, tbl[t].exp_sum);
            check($sformatf("v%0d_max", t), max_value, tbl[t].exp_max);
            check($sformatf("v%0d_ovf", t), overflow, tbl[t].exp_ovf);
            check($sformatf("v%0d_done", t), done, 1);
            check($sformatf("v%0d_req", t), list_req, 0);
        end

        // 300 x 255: count wraps to 44, sum saturates.
        start_collection(1'b0);
        for (int i = 0; i < 300; i++) begin
            ack_element(8'd255, 1'b1, 0);
            release_ack(0);
        end
        ack_element(8'd0, 1'b0, 0);
        release_ack(0);
        check("sat_count", count, 44);
        check("sat_sum", sum, 65535);
        check("sat_max", max_value, 255);
        check("sat_ovf", overflow, 1);
        check("sat_done", done, 1);

        // start held high across and after a collection must not retrigger.
        start_collection(1'b1);
        ack_element(8'd1, 1'b1, 0);
        release_ack(0);
        ack_element(8'd2, 1'b1, 0);
        release_ack(0);
        ack_element(8'd0, 1'b0, 0);
        release_ack(0);
        for (int i = 0; i < 4; i++) begin
            check("held_start_req", list_req, 0);
            check("held_start_done", done, 1);
            tick();
        end
        check("held_start_count", count, 2);
        start = 1'b0;

        // Stalled producer.
        start_collection(1'b0);
        n_req = 0;
        while (list_req === 1'b1 && n_req < 100) begin
            tick();
            n_req++;
        end
        check("tmo_req_cycles", n_req, Tmo);
        check("tmo_flag", timeout, 1);
        check("tmo_done", done, 1);
        check("tmo_req_low", list_req, 0);
        list_ack   = 1'b1;
        list_valid = 1'b1;
        list_value = 8'd50;
        tick();
        tick();
        list_ack   = 1'b0;
        list_valid = 1'b0;
        tick();
        check("err_ack_count", count, 0);
        check("err_hold_timeout", timeout, 1);
        check("err_hold_done", done, 1);
        start_collection(1'b0);
        ack_element(8'd4, 1'b1, 1);
        release_ack(0);
        ack_element(8'd0, 1'b0, 0);
        release_ack(0);
        check("tmo_restart_count", count, 1);
        check("tmo_restart_sum", sum, 4);

        // Reset while in RELEASE with ack still high.
        start_collection(1'b0);
        ack_element(8'd20, 1'b1, 0);
        release_ack(0);
        ack_element(8'd30, 1'b1, 1);
        reset_n = 1'b0;
        tick();
        check("midrst_count", count, 0);
        check("midrst_sum", sum, 0);
        check("midrst_max", max_value, 0);
        check("midrst_req", list_req, 0);
        check("midrst_done", done, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_timeout", timeout, 0);
        reset_n    = 1'b1;
        list_ack   = 1'b0;
        list_valid = 1'b0;
        tick();
        check("midrst_idle_req", list_req, 0);
        start_collection(1'b0);
        ack_element(8'd10, 1'b1, 0);
        release_ack(0);
        ack_element(8'd0, 1'b0, 0);
        release_ack(0);
        check("fresh_count", count, 1);
        check("fresh_sum", sum, 10);
        check("fresh_max", max_value, 10);
        check("fresh_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
